// File: rtl/usb_bit_stuffer_if.sv
// usb_bit_stuffer_if: bit-stream signals between packet encoder, bit stuffer and NRZI encoder.
// master = encoder/line side, slave = the stuffer.
interface usb_bit_stuffer_if;
   logic in_bit, in_valid, in_sop, in_eop, in_ready;
   logic out_bit, out_valid, out_sop, out_eop;
   modport master(output in_bit, in_valid, in_sop, in_eop,
                  input in_ready, out_bit, out_valid, out_sop, out_eop);
   modport slave(input in_bit, in_valid, in_sop, in_eop,
                 output in_ready, out_bit, out_valid, out_sop, out_eop);
endinterface

// File: rtl/usb_bit_stuffer.sv
// usb_bit_stuffer: inserts a 0 after every STUFF_LEN consecutive 1s, stalling the encoder one cycle per stuff.
// Define USB_STUFF_STATS_EN to add the saturating stuff_cnt statistics port.
module usb_bit_stuffer #(
`ifdef USB_STUFF_STATS_EN
   parameter int CNT_W = 16,
`endif
   parameter int STUFF_LEN = 6
) (
   input logic clk,
   input logic rst_L,
`ifdef USB_STUFF_STATS_EN
   output logic [CNT_W-1:0] stuff_cnt,
`endif
   usb_bit_stuffer_if.slave s
);
   typedef enum logic {PASS, STUFF} state_t;
   state_t state;
   logic [2:0] ones_cnt, start, nxt;
   logic hit, eop_pend;
   always_comb begin
      start = s.in_sop ? 3'd0 : ones_cnt;
      nxt = s.in_bit ? start + 3'd1 : 3'd0;
      hit = nxt == 3'(STUFF_LEN);
   end
   assign s.in_ready = state == PASS;
   // An EOP on the triggering 1 is parked in eop_pend and emitted with the stuffed 0.
   always_ff @(posedge clk or negedge rst_L)
      if (!rst_L) begin
         state <= PASS;
         ones_cnt <= 3'd0;
         eop_pend <= 1'b0;
         s.out_bit <= 1'b0;
         s.out_valid <= 1'b0;
         s.out_sop <= 1'b0;
         s.out_eop <= 1'b0;
`ifdef USB_STUFF_STATS_EN
         stuff_cnt <= '0;
`endif
      end else if (state == STUFF) begin
         s.out_bit <= 1'b0;
         s.out_valid <= 1'b1;
         s.out_sop <= 1'b0;
         s.out_eop <= eop_pend;
         eop_pend <= 1'b0;
         state <= PASS;
`ifdef USB_STUFF_STATS_EN
         if (stuff_cnt != '1) stuff_cnt <= stuff_cnt + 1'b1;
`endif
      end else if (s.in_valid) begin
         s.out_bit <= s.in_bit;
         s.out_valid <= 1'b1;
         s.out_sop <= s.in_sop;
         s.out_eop <= s.in_eop & ~hit;
         eop_pend <= s.in_eop & hit;
         ones_cnt <= (hit || s.in_eop) ? 3'd0 : nxt;
         state <= hit ? STUFF : PASS;
      end else begin
         s.out_valid <= 1'b0;
         s.out_sop <= 1'b0;
         s.out_eop <= 1'b0;
      end
endmodule

// File: tb/tb_usb_bit_stuffer.sv
// tb_usb_bit_stuffer: scoreboard bench for usb_bit_stuffer; expected output bits are queued as stimulus is accepted.
module tb_usb_bit_stuffer;
   localparam int SL = 6;
   logic clk = 1'b0;
   logic rst_L = 1'b0;
   int checks = 0, errors = 0, stalls = 0, ones = 0, nstuff = 0;
   int holes = 0, gap = 0, seen = 0;
   logic [2:0] exp_q[$];
   logic [2:0] got[$];
   usb_bit_stuffer_if ifc();
`ifdef USB_STUFF_STATS_EN
   logic [15:0] stuff_cnt;
   usb_bit_stuffer #(.STUFF_LEN(SL)) dut(.clk(clk), .rst_L(rst_L), .stuff_cnt(stuff_cnt), .s(ifc.slave));
`else
   usb_bit_stuffer #(.STUFF_LEN(SL)) dut(.clk(clk), .rst_L(rst_L), .s(ifc.slave));
`endif
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: expected {bit,sop,eop} words for one accepted input bit.
   task automatic model(input logic b, input logic sp, input logic ep);
      int st, nx;
      st = sp ? 0 : ones;
      nx = b ? st + 1 : 0;
      if (nx == SL) begin
         exp_q.push_back({b, sp, 1'b0});
         exp_q.push_back({1'b0, 1'b0, ep});
         ones = 0;
         nstuff++;
      end else begin
         exp_q.push_back({b, sp, ep});
         ones = ep ? 0 : nx;
      end
   endtask

   // Called at a negedge; returns at the negedge after the bit was accepted.
   task automatic send(input logic b, input logic sp, input logic ep);
      int n = 0;
      ifc.in_bit = b;
      ifc.in_sop = sp;
      ifc.in_eop = ep;
      ifc.in_valid = 1'b1;
      while (!ifc.in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n == 10) check("ready_timeout", 0, 1);
      stalls += n;
      model(b, sp, ep);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_sop = 1'b0;
      ifc.in_eop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr();
      got.delete();
      holes = 0;
      gap = 0;
      seen = 0;
      stalls = 0;
   endtask

   always @(negedge clk)
      if (rst_L) begin
         if (ifc.out_valid) begin
            got.push_back({ifc.out_bit, ifc.out_sop, ifc.out_eop});
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check("sb_out", {ifc.out_bit, ifc.out_sop, ifc.out_eop}, exp_q.pop_front());
            holes += gap;
            gap = 0;
            seen = 1;
         end else begin
            check("idle_flags", {ifc.out_sop, ifc.out_eop}, 0);
            if (seen != 0) gap++;
         end
      end

   initial begin
      logic [7:0] v;
      ifc.in_valid = 1'b0;
      ifc.in_bit = 1'b0;
      ifc.in_sop = 1'b0;
      ifc.in_eop = 1'b0;
      #3;
      check("rst_out", {ifc.out_bit, ifc.out_valid, ifc.out_sop, ifc.out_eop}, 0);
      idle(2);
      rst_L = 1'b1;
      idle(1);
      check("rst_ready", ifc.in_ready, 1);
      // 8'hFF framed packet
      clr();
      v = 8'hFF;
      for (int i = 0; i < 8; i++) send(v[i], i == 0, i == 7);
      idle(4);
      check("t1_len", got.size(), 9);
      for (int i = 0; i < 9 && i < got.size(); i++) check("t1_bit", got[i][2], i == 6 ? 0 : 1);
      if (got.size() == 9) check("t1_eop", {got[7][0], got[8][0]}, 2'b01);
      check("t1_stall", stalls, 1);
      check("t1_holes", holes, 0);
      // five 1s only, no stuffing
      clr();
      v = 8'h3E;
      for (int i = 0; i < 8; i++) send(v[i], i == 0, i == 7);
      idle(4);
      check("t2_len", got.size(), 8);
      check("t2_stall", stalls, 0);
      // twelve 1s then 0
      clr();
      for (int i = 0; i < 13; i++) send(i < 12, i == 0, i == 12);
      idle(4);
      check("t3_len", got.size(), 15);
      if (got.size() == 15) check("t3_stuff", {got[6][2], got[13][2]}, 0);
`ifdef USB_STUFF_STATS_EN
      check("t3_cnt", stuff_cnt, nstuff);
`endif
      // run of 1s spanning a 3-cycle gap
      clr();
      for (int i = 0; i < 3; i++) send(1'b1, i == 0, 1'b0);
      idle(3);
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b1);
      idle(4);
      check("t4_len", got.size(), 8);
      check("t4_holes", holes, 3);
      if (got.size() == 8) check("t4_stuff", got[6], 3'b000);
      // EOP on the 6th 1, then a new packet
      clr();
      for (int i = 0; i < 6; i++) send(1'b1, i == 0, i == 5);
      for (int i = 0; i < 6; i++) send(1'b1, i == 0, 1'b0);
      send(1'b1, 1'b0, 1'b1);
      idle(4);
      check("t5_len", got.size(), 15);
      if (got.size() == 15) begin
         check("t5_eop1", got[5], 3'b100);
         check("t5_eop0", got[6], 3'b001);
         check("t5_sop", got[7], 3'b110);
         check("t5_stuff2", got[13], 3'b000);
      end
      // reset while a stuff is pending
      clr();
      for (int i = 0; i < 6; i++) send(1'b1, i == 0, 1'b0);
      check("t6_instuff", ifc.in_ready, 0);
      #2 rst_L = 1'b0;
      #1;
      check("t6_async", {ifc.out_bit, ifc.out_valid, ifc.out_sop, ifc.out_eop}, 0);
      check("t6_ready", ifc.in_ready, 1);
      exp_q.delete();
      ones = 0;
      idle(1);
      rst_L = 1'b1;
      idle(1);
      check("t6_ready_rel", ifc.in_ready, 1);
      idle(3);
      check("t6_nostuff", got.size(), 6);
`ifdef USB_STUFF_STATS_EN
      check("t6_cnt", stuff_cnt, 0);
`endif
      send(1'b1, 1'b1, 1'b1);
      idle(3);
      check("t6_single", got.size(), 7);
      if (got.size() == 7) check("t6_sopeop", got[6], 3'b111);
      check("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
